// File: rtl/hex_segments_reader.sv
// Seven-segment pattern reader: waits for a pattern to hold steady, decodes it to a hex digit
// and offers it on a valid/ready output with a sticky overrun flag for dropped captures.
module hex_segments_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] leds,
   input  logic       sample_en,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] value,
   output logic       blank,
   output logic       illegal,
   output logic       overrun
);

   localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   typedef enum logic {
      SETTLE = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Returns {value[3:0], blank, illegal} for an active-low segment code.
   function automatic logic [5:0] decode(input logic [6:0] seg);
      logic [5:0] res;
      res = {4'h0, 1'b0, 1'b1};
      case (seg)
         7'h40: res = {4'h0, 2'b00};
         7'h79: res = {4'h1, 2'b00};
         7'h24: res = {4'h2, 2'b00};
         7'h30: res = {4'h3, 2'b00};
         7'h19: res = {4'h4, 2'b00};
         7'h12: res = {4'h5, 2'b00};
         7'h02: res = {4'h6, 2'b00};
         7'h78: res = {4'h7, 2'b00};
         7'h00: res = {4'h8, 2'b00};
         7'h10: res = {4'h9, 2'b00};
         7'h08: res = {4'hA, 2'b00};
         7'h03: res = {4'hB, 2'b00};
         7'h46: res = {4'hC, 2'b00};
         7'h21: res = {4'hD, 2'b00};
         7'h06: res = {4'hE, 2'b00};
         7'h0E: res = {4'hF, 2'b00};
         7'h7F: res = {4'h0, 2'b10};
         default: res = {4'h0, 1'b0, 1'b1};
      endcase
      return res;
   endfunction

   state_t     state, state_next;
   logic [6:0] leds_q;
   logic [7:0] cnt, cnt_next;
   logic       match;
   logic       capture;
   logic       accept;
   logic [5:0] dec;

   logic       vld_p1;
   logic [3:0] value_p1;
   logic       blank_p1;
   logic       illegal_p1;
   logic       overrun_p1;

   assign match  = sample_en & (leds == leds_q);
   assign dec    = decode(leds_q);
   assign accept = capture & (~vld_p1 | out_ready);

   always_comb begin
      state_next = state;
      cnt_next   = 8'd0;
      capture    = 1'b0;
      if (match) begin
         cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + 8'd1;
      end
      case (state)
         SETTLE: begin
            if (match && (cnt == CNT_LAST)) begin
               capture    = 1'b1;
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (!match) begin
               state_next = SETTLE;
            end
         end
         default: state_next = SETTLE;
      endcase
   end

   // Stage 0: input register and stability tracking
   always_ff @(posedge clock) begin
      if (reset) begin
         leds_q <= 7'h7F;
         cnt    <= 8'd0;
         state  <= SETTLE;
      end else begin
         leds_q <= leds;
         cnt    <= cnt_next;
         state  <= state_next;
      end
   end

   // Stage 1: result register, handshake and overrun
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p1     <= 1'b0;
         value_p1   <= 4'h0;
         blank_p1   <= 1'b0;
         illegal_p1 <= 1'b0;
         overrun_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1     <= 1'b1;
         value_p1   <= dec[5:2];
         blank_p1   <= dec[1];
         illegal_p1 <= dec[0];
      end else if (capture) begin
         overrun_p1 <= 1'b1;
      end else if (vld_p1 && out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign value     = value_p1;
   assign blank     = blank_p1;
   assign illegal   = illegal_p1;
   assign overrun   = overrun_p1;

endmodule
